uart_host_rx: RTL and testbench
===============================

Name: uart_host_rx

Overview:
- UART receiver that feeds the host loader control block: deserialises 8N1 frames from the host serial line into bytes.
- Presents each byte on a data/valid/ack handshake and drives the done flag that marks end of a host transfer.
- Single clock domain. Only rx_i is asynchronous; it is synchronised internally.

Parameters:
- CLKS_PER_BIT, 434: clock cycles per UART bit (50 MHz / 115200); must be >= 8.
- IDLE_BITS, 32: idle line bit-times, with no byte pending, before done_o asserts.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- rx_i  in  1  asynchronous serial input; idles high.
- ack_i  in  1  consumer accepts current byte; only meaningful while valid_o=1.
- data_o  out  8  received byte; stable while valid_o=1.
- valid_o  out  1  byte pending in holding register.
- done_o  out  1  1 = no transfer in progress; 0 = host transfer active.
- frame_err_o  out  1  one-cycle pulse: stop bit sampled low.
- overrun_o  out  1  one-cycle pulse: new byte dropped because holding register was full.

Behaviour:
- Reset values (synchronous, active-high):
  - Synchroniser flops = 1; state = IDLE; counters = 0.
  - data_o = 0x00; valid_o = 0; done_o = 1; frame_err_o = 0; overrun_o = 0.
  - Reset mid-frame discards the partial byte and any pending byte.
- Synchroniser: 2-flop on rx_i. All decisions use the second flop (rxs).
- State IDLE:
  - rxs=0 -> START, bit counter cleared.
  - Otherwise the idle counter increments.
- State START:
  - At count CLKS_PER_BIT/2-1 (integer division), sample rxs.
  - rxs=0 -> DATA, counter cleared, done_o <= 0.
  - rxs=1 (glitch) -> IDLE, nothing reported.
- State DATA:
  - Every CLKS_PER_BIT cycles, sample rxs into the shift register, LSB first (first data bit = bit 0).
  - After the 8th sample -> STOP.
- State STOP, after CLKS_PER_BIT cycles sample rxs:
  - rxs=1: deliver byte -> IDLE.
  - rxs=0: frame_err_o pulses 1 cycle, byte discarded -> WAIT_HIGH.
- State WAIT_HIGH: stay until rxs=1, then -> IDLE. A line held low is never taken as a new start bit.
- Delivery, on the stop-sample cycle:
  - If valid_o=0, or valid_o=1 and ack_i=1 in the same cycle: data_o <= byte and valid_o <= 1. valid_o is visible the cycle after the stop sample.
  - Otherwise: overrun_o pulses 1 cycle, new byte dropped, data_o and valid_o unchanged.
- Handshake:
  - ack_i=1 while valid_o=1 clears valid_o on the next edge, unless a simultaneous delivery reloads it.
  - ack_i while valid_o=0 is ignored.
  - data_o holds its last value after ack.
- Idle counter:
  - Cleared on entry to START and while valid_o=1.
  - Saturates at IDLE_BITS*CLKS_PER_BIT; width = clog2 of that value + 1.
  - When saturated and valid_o=0: done_o <= 1.
- done_o:
  - Only falls on a validated start bit; only rises via the idle timeout.
  - Glitches and framing errors on an idle line leave done_o unchanged.
  - A framing error mid-transfer leaves done_o = 0.
- Receiver runs continuously, independent of the handshake; frames are never stalled.

Test Plan (CLKS_PER_BIT=16, IDLE_BITS=4):
- Send 0xA5 8N1, ack_i held 0 -> valid_o=1 from the cycle after the stop sample; data_o=0xA5; done_o=0; no error pulses.
- rx_i low for 4 cycles, then high -> no valid_o, no frame_err_o; done_o stays 1; state returns to IDLE.
- Frame 0x3C with stop bit driven 0, line released high 20 cycles later -> one frame_err_o pulse; valid_o stays 0; next frame 0x11 received correctly.
- Frames 0x01 then 0x02, no ack -> overrun_o pulse at the second stop sample; data_o=0x01; valid_o=1. Then ack_i one cycle -> valid_o=0 next edge.
- Back-to-back 0x55, 0xAA, with ack_i pulsed on the exact cycle 0xAA's stop sample completes -> data_o=0xAA; valid_o stays 1; no overrun.
- 0x7E, then ack, then idle line -> done_o=1 exactly 64 cycles after the last idle-counter clear. Assert rst_i mid-DATA of a later frame -> all outputs at reset values the next cycle, no partial byte delivered.

Source files
------------

// File: rtl/uart_host_rx.sv
// uart_host_rx: 8N1 UART receiver with valid/ack byte handoff and an idle-timeout host-transfer done flag
module uart_host_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int IDLE_BITS    = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    input  logic       ack_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       done_o,
    output logic       frame_err_o,
    output logic       overrun_o
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_HIGH = 3'd4;
    localparam int CW       = $clog2(CLKS_PER_BIT);
    localparam int IDLE_MAX = IDLE_BITS * CLKS_PER_BIT;
    localparam int IW       = $clog2(IDLE_MAX) + 1;
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDLE_SAT = IW'(IDLE_MAX);

    logic          rx_meta, rxs;
    logic [2:0]    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [IW-1:0] idle_cnt, idle_nxt;
    logic          half_hit, bit_hit, stop_sample, deliver;

    assign half_hit    = cnt == HALF_END;
    assign bit_hit     = cnt == BIT_END;
    assign stop_sample = (state == STOP) && bit_hit;
    assign deliver     = stop_sample && rxs && (!valid_o || ack_i);
    // done rises on the same edge the idle counter reaches saturation
    assign idle_nxt = (valid_o || (state == IDLE && !rxs)) ? '0 :
                      (state == IDLE && idle_cnt != IDLE_SAT) ? idle_cnt + 1'b1 : idle_cnt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!rxs) state_nxt = START;
            end
            START: if (half_hit) begin
                cnt_nxt   = '0;
                state_nxt = rxs ? IDLE : DATA;
            end
            DATA: if (bit_hit) begin
                cnt_nxt = '0;
                if (bit_idx == 3'd7) state_nxt = STOP;
            end
            STOP: if (bit_hit) begin
                cnt_nxt   = '0;
                state_nxt = rxs ? IDLE : WAIT_HIGH;
            end
            WAIT_HIGH: begin
                cnt_nxt = '0;
                if (rxs) state_nxt = IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta     <= 1'b1;
            rxs         <= 1'b1;
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            idle_cnt    <= '0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            done_o      <= 1'b1;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            rx_meta     <= rx_i;
            rxs         <= rx_meta;
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            idle_cnt    <= idle_nxt;
            frame_err_o <= stop_sample && !rxs;
            overrun_o   <= stop_sample && rxs && valid_o && !ack_i;
            if (state == IDLE) bit_idx <= '0;
            if (state == DATA && bit_hit) begin
                shreg   <= {rxs, shreg[7:1]};
                bit_idx <= bit_idx + 1'b1;
            end
            if (state == START && half_hit && !rxs) done_o <= 1'b0;
            else if (idle_nxt == IDLE_SAT && !valid_o) done_o <= 1'b1;
            if (deliver) begin
                data_o  <= shreg;
                valid_o <= 1'b1;
            end else if (ack_i) begin
                valid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_host_rx.sv
// tb_uart_host_rx: directed bench for uart_host_rx at 16 clocks per bit, 4 idle bit-times
module tb_uart_host_rx;
    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       rx_i  = 1'b1;
    logic       ack_i = 1'b0;
    logic [7:0] data_o;
    logic       valid_o, done_o, frame_err_o, overrun_o;
    int         passed = 0, total = 0;
    int         fe_cnt = 0, ov_cnt = 0;
    int         fe0, ov0, n;
    logic       v154, v155, o155, f155;
    logic [7:0] d155;

    uart_host_rx #(.CLKS_PER_BIT(16), .IDLE_BITS(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .rx_i(rx_i), .ack_i(ack_i),
        .data_o(data_o), .valid_o(valid_o), .done_o(done_o),
        .frame_err_o(frame_err_o), .overrun_o(overrun_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (frame_err_o === 1'b1) fe_cnt++;
        if (overrun_o === 1'b1) ov_cnt++;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    // Drives len ticks of an 8N1 frame; the stop sample commits on the edge ending tick 154
    task automatic send_frame(input logic [7:0] b, input logic stop, input int ack_tick, input int len);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < len; i++) begin
            rx_i  = bits[i / 16];
            ack_i = (i == ack_tick);
            if (i == 154) v154 = valid_o;
            if (i == 155) begin
                v155 = valid_o;
                d155 = data_o;
                o155 = overrun_o;
                f155 = frame_err_o;
            end
            tick();
        end
        ack_i = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_data", data_o, 8'h00);
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_done", done_o, 1'b1);
        chk("rst_ferr", frame_err_o, 1'b0);
        chk("rst_ovr", overrun_o, 1'b0);
        rst_i = 1'b0;
        repeat (4) tick();
        chk("idle_done", done_o, 1'b1);

        send_frame(8'hA5, 1'b1, -1, 160);
        chk("a5_pre_valid", v154, 1'b0);
        chk("a5_valid", v155, 1'b1);
        chk("a5_data", d155, 8'hA5);
        chk("a5_ovr", o155, 1'b0);
        chk("a5_ferr", f155, 1'b0);
        chk("a5_done", done_o, 1'b0);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        chk("a5_ack", valid_o, 1'b0);
        repeat (80) tick();
        chk("timeout_done", done_o, 1'b1);

        fe0  = fe_cnt;
        rx_i = 1'b0;
        repeat (4) tick();
        rx_i = 1'b1;
        repeat (20) tick();
        chk("glitch_valid", valid_o, 1'b0);
        chk("glitch_ferr", fe_cnt - fe0, 0);
        chk("glitch_done", done_o, 1'b1);
        chk("glitch_state", dut.state, 3'd0);

        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0, -1, 160);
        chk("ferr_pulse", f155, 1'b1);
        repeat (20) tick();
        rx_i = 1'b1;
        repeat (8) tick();
        chk("ferr_count", fe_cnt - fe0, 1);
        chk("ferr_valid", valid_o, 1'b0);
        send_frame(8'h11, 1'b1, -1, 160);
        chk("after_ferr_valid", v155, 1'b1);
        chk("after_ferr_data", d155, 8'h11);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;

        ov0 = ov_cnt;
        send_frame(8'h01, 1'b1, -1, 160);
        send_frame(8'h02, 1'b1, -1, 160);
        chk("ovr_pulse", o155, 1'b1);
        chk("ovr_count", ov_cnt - ov0, 1);
        chk("ovr_data", data_o, 8'h01);
        chk("ovr_valid", valid_o, 1'b1);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        chk("ovr_ack_valid", valid_o, 1'b0);
        chk("ovr_ack_hold", data_o, 8'h01);

        ov0 = ov_cnt;
        send_frame(8'h55, 1'b1, -1, 160);
        chk("b2b_55", d155, 8'h55);
        send_frame(8'hAA, 1'b1, 154, 160);
        chk("b2b_ovr_pulse", o155, 1'b0);
        chk("b2b_valid", v155, 1'b1);
        chk("b2b_data", d155, 8'hAA);
        chk("b2b_ovr_count", ov_cnt - ov0, 0);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;

        send_frame(8'h7E, 1'b1, -1, 160);
        chk("7e_data", d155, 8'h7E);
        chk("7e_done", done_o, 1'b0);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        n = 0;
        while (done_o !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("done_latency", n, 64);

        send_frame(8'h99, 1'b1, -1, 160);
        send_frame(8'hF0, 1'b1, -1, 60);
        chk("mid_state", dut.state, 3'd2);
        rst_i = 1'b1;
        rx_i  = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("mid_rst_data", data_o, 8'h00);
        chk("mid_rst_valid", valid_o, 1'b0);
        chk("mid_rst_done", done_o, 1'b1);
        chk("mid_rst_ferr", frame_err_o, 1'b0);
        chk("mid_rst_ovr", overrun_o, 1'b0);
        repeat (200) tick();
        chk("post_rst_valid", valid_o, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
